// File: rtl/xor_if_pkg.sv
// xor_if_pkg: shared state encoding, default sizes and saturating increment for the XOR operand interface
package xor_if_pkg;
  typedef enum logic {IDLE, ISSUE} state_t;
  localparam int CNT_W_DEF = 16;
  localparam int EXP_DEPTH_DEF = 4;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    return (v == (32'd1 << w) - 32'd1) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/xor_exp_fifo.sv
// xor_exp_fifo: 1-bit synchronous FIFO of expected results with same-edge push and pop
module xor_exp_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       din,
  input  logic                       pop,
  output logic                       dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [DEPTH-1:0] mem;
  logic [AW-1:0] wp, rp;
  assign dout = mem[rp];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  // pointers and occupancy; callers never push when full or pop when empty
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/xor_pair_initiator.sv
// xor_pair_initiator: issues A/B operand pairs to an XOR responder and checks the returned Y results
module xor_pair_initiator
  import xor_if_pkg::*;
#(
  parameter int EXP_DEPTH = EXP_DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_a,
  input  logic             cmd_b,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  output logic             A_data,
  output logic             A_enable,
  input  logic             A_ready,
  output logic             B_data,
  output logic             B_enable,
  input  logic             B_ready,
  input  logic             Y_data,
  input  logic             Y_enable,
  output logic             Y_ready,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] err_count,
  output logic             mismatch,
  output logic             spurious,
  output logic             busy
);
  localparam int AW = $clog2(EXP_DEPTH);
  state_t state, state_nx;
  logic accept, a_hs, b_hs, y_hs, exp_bit, full, empty;
  logic [AW:0] fifo_count;
  assign cmd_ready = (state == IDLE) && !full;
  assign accept = cmd_valid && cmd_ready;
  assign a_hs = A_enable && A_ready;
  assign b_hs = B_enable && B_ready;
  assign Y_ready = |fifo_count;
  assign y_hs = Y_enable && Y_ready;
  assign busy = (state != IDLE) || !empty;
  xor_exp_fifo #(.DEPTH(EXP_DEPTH)) u_fifo (
    .clk(clk), .reset_n(reset_n), .push(accept), .din(cmd_a ^ cmd_b), .pop(y_hs),
    .dout(exp_bit), .full(full), .empty(empty), .count(fifo_count)
  );
  // state register
  always_ff @(posedge clk) state <= !reset_n ? IDLE : state_nx;
  // leave ISSUE once whichever of A/B is still outstanding completes its handshake
  always_comb begin
    state_nx = state;
    if (state == IDLE)
      state_nx = accept ? ISSUE : IDLE;
    else
      state_nx = ((!A_enable || a_hs) && (!B_enable || b_hs)) ? IDLE : ISSUE;
  end
  // operand drive: load both channels on accept, drop each enable on its own handshake
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      A_data <= 1'b0;
      B_data <= 1'b0;
      A_enable <= 1'b0;
      B_enable <= 1'b0;
    end else if (accept) begin
      A_data <= cmd_a;
      B_data <= cmd_b;
      A_enable <= 1'b1;
      B_enable <= 1'b1;
    end else begin
      if (a_hs) A_enable <= 1'b0;
      if (b_hs) B_enable <= 1'b0;
    end
  end
  // result checker: compare consumed Y against queue head and count the outcome
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pass_count <= '0;
      err_count <= '0;
      mismatch <= 1'b0;
      spurious <= 1'b0;
    end else begin
      mismatch <= y_hs && (Y_data != exp_bit);
      spurious <= spurious || (Y_enable && empty);
      if (y_hs && Y_data == exp_bit) pass_count <= CNT_W'(sat_inc(32'(pass_count), CNT_W));
      if (y_hs && Y_data != exp_bit) err_count <= CNT_W'(sat_inc(32'(err_count), CNT_W));
    end
  end
endmodule

// File: tb/tb_xor_pair_initiator.sv
// tb_xor_pair_initiator: scoreboard bench with a behavioural XOR responder for xor_pair_initiator
module tb_xor_pair_initiator;
  logic clk = 0, reset_n = 0, cmd_a = 0, cmd_b = 0, cmd_valid = 0;
  logic A_ready = 0, B_ready = 0, Y_data = 0, Y_enable = 0;
  logic cmd_ready, A_data, A_enable, B_data, B_enable, Y_ready, mismatch, spurious, busy;
  logic [15:0] pass_count, err_count;
  int checks = 0, errors = 0, mp = 0, me = 0, mis_pulses = 0;
  bit y_hold = 0, y_force = 0, corrupt = 0, last_acc = 0, exp_mis = 0;
  bit pa_en = 0, pb_en = 0, pad = 0, pbd = 0;
  bit exp_q[$], ca_q[$], cb_q[$], ra_q[$], rb_q[$];

  xor_pair_initiator #(.EXP_DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .A_data(A_data), .A_enable(A_enable), .A_ready(A_ready),
    .B_data(B_data), .B_enable(B_enable), .B_ready(B_ready), .Y_data(Y_data),
    .Y_enable(Y_enable), .Y_ready(Y_ready), .pass_count(pass_count), .err_count(err_count),
    .mismatch(mismatch), .spurious(spurious), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // one clock: responder drives Y at negedge, model updates at posedge, outputs checked 1 after
  task automatic cyc();
    bit acc, ah, bh, yh, ad, bd, yd, e;
    @(negedge clk);
    Y_enable = y_force || (!y_hold && ra_q.size() > 0 && rb_q.size() > 0);
    Y_data = 1'b0;
    if (!y_force && ra_q.size() > 0 && rb_q.size() > 0)
      Y_data = ra_q[0] ^ rb_q[0] ^ (corrupt & ra_q[0] & rb_q[0]);
    #1;
    if (pa_en && A_enable) chk("a_stable", A_data, pad);
    if (pb_en && B_enable) chk("b_stable", B_data, pbd);
    acc = cmd_valid && cmd_ready;
    ah = A_enable && A_ready;
    bh = B_enable && B_ready;
    yh = Y_enable && Y_ready;
    ad = A_data;
    bd = B_data;
    yd = Y_data;
    pa_en = A_enable && !A_ready && reset_n;
    pb_en = B_enable && !B_ready && reset_n;
    pad = A_data;
    pbd = B_data;
    @(posedge clk);
    last_acc = acc && reset_n;
    exp_mis = 0;
    if (!reset_n) begin
      exp_q.delete(); ca_q.delete(); cb_q.delete(); ra_q.delete(); rb_q.delete();
      mp = 0;
      me = 0;
    end else begin
      if (acc) begin
        exp_q.push_back(cmd_a ^ cmd_b);
        ca_q.push_back(cmd_a);
        cb_q.push_back(cmd_b);
      end
      if (ah) begin
        if (ca_q.size() == 0) chk("a_extra", 1, 0);
        else begin
          chk("a_data", ad, ca_q.pop_front());
          ra_q.push_back(ad);
        end
      end
      if (bh) begin
        if (cb_q.size() == 0) chk("b_extra", 1, 0);
        else begin
          chk("b_data", bd, cb_q.pop_front());
          rb_q.push_back(bd);
        end
      end
      if (yh) begin
        if (exp_q.size() == 0 || ra_q.size() == 0 || rb_q.size() == 0) chk("y_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          void'(ra_q.pop_front());
          void'(rb_q.pop_front());
          if (!corrupt) chk("y_data", yd, e);
          if (yd == e) mp++;
          else begin
            me++;
            exp_mis = 1;
          end
        end
      end
    end
    #1;
    chk("pass_count", pass_count, mp);
    chk("err_count", err_count, me);
    chk("mismatch", mismatch, exp_mis);
    if (mismatch) mis_pulses++;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic send(input bit a, input bit b);
    cmd_a = a;
    cmd_b = b;
    cmd_valid = 1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (last_acc) break;
    end
    chk("send_accept", last_acc, 1);
    cmd_valid = 0;
  endtask

  initial begin
    A_ready = 1;
    B_ready = 1;
    run(2);
    reset_n = 1;
    chk("rst_a_en", A_enable, 0);
    chk("rst_b_en", B_enable, 0);
    chk("rst_a_data", A_data, 0);
    chk("rst_b_data", B_data, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_y_ready", Y_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_spurious", spurious, 0);
    y_force = 1;
    run(1);
    chk("sp_y_ready", Y_ready, 0);
    run(2);
    chk("sp_set", spurious, 1);
    y_force = 0;
    run(3);
    chk("sp_sticky", spurious, 1);
    reset_n = 0;
    run(1);
    reset_n = 1;
    chk("sp_clear", spurious, 0);
    send(1, 0);
    chk("t1_a_en", A_enable, 1);
    chk("t1_b_en", B_enable, 1);
    run(4);
    chk("t1_pass", pass_count, 1);
    chk("t1_err", err_count, 0);
    chk("t1_idle", busy, 0);
    A_ready = 0;
    send(0, 1);
    run(1);
    chk("t2_b_drop", B_enable, 0);
    chk("t2_a_hold", A_enable, 1);
    chk("t2_cr_low", cmd_ready, 0);
    run(2);
    chk("t2_cr_still_low", cmd_ready, 0);
    chk("t2_a_data", A_data, 0);
    A_ready = 1;
    run(1);
    chk("t2_a_drop", A_enable, 0);
    chk("t2_cr_up", cmd_ready, 1);
    run(3);
    chk("t2_pass", pass_count, 2);
    y_hold = 1;
    send(0, 0);
    send(0, 1);
    send(1, 0);
    send(1, 1);
    run(2);
    cmd_valid = 1;
    run(3);
    chk("t3_full_cr", cmd_ready, 0);
    chk("t3_no_accept", last_acc, 0);
    chk("t3_busy", busy, 1);
    chk("t3_y_ready", Y_ready, 1);
    cmd_valid = 0;
    y_hold = 0;
    run(8);
    chk("t3_pass", pass_count, 6);
    chk("t3_drained", Y_ready, 0);
    corrupt = 1;
    mis_pulses = 0;
    send(1, 1);
    run(5);
    corrupt = 0;
    chk("t4_err", err_count, 1);
    chk("t4_pulses", mis_pulses, 1);
    chk("t4_pass", pass_count, 6);
    y_hold = 1;
    send(1, 0);
    send(0, 0);
    run(2);
    A_ready = 0;
    B_ready = 0;
    send(1, 1);
    chk("t6_busy", busy, 1);
    reset_n = 0;
    run(1);
    reset_n = 1;
    chk("t6_a_en", A_enable, 0);
    chk("t6_b_en", B_enable, 0);
    chk("t6_busy", busy, 0);
    chk("t6_y_ready", Y_ready, 0);
    chk("t6_pass", pass_count, 0);
    chk("t6_err", err_count, 0);
    chk("t6_cr", cmd_ready, 1);
    A_ready = 1;
    B_ready = 1;
    y_hold = 0;
    run(4);
    chk("t6_quiet_pass", pass_count, 0);
    chk("t6_spurious", spurious, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
